// File: rtl/elbeth_fetch_pkg.sv
// Shared types and constants for the ELBETH instruction fetch stage.
package elbeth_fetch_pkg;

    typedef enum logic [1:0] {
        FETCH_REQ  = 2'd0,
        FETCH_FULL = 2'd1,
        FETCH_KILL = 2'd2,
        FETCH_HALT = 2'd3
    } fetch_state_e;

    localparam logic [1:0] FETCH_EXC_NONE     = 2'd0;
    localparam logic [1:0] FETCH_EXC_MISALIGN = 2'd1;
    localparam logic [1:0] FETCH_EXC_BUSERR   = 2'd2;

    localparam logic [31:0] NOP_INSN_DEFAULT = 32'h0000_0013;

    function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/elbeth_if_id_reg.sv
// IF/ID pipeline register with a one-entry skid buffer.
// Priority for the ID slot: load, then skid pop, then flush/advance (bubble).
module elbeth_if_id_reg
    import elbeth_fetch_pkg::*;
#(
    parameter logic [31:0] NOP_INSN = NOP_INSN_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic        push,
    input  logic        pop,
    input  logic        flush,
    input  logic        advance,
    input  logic [31:0] in_pc,
    input  logic [31:0] in_insn,
    input  logic [1:0]  in_exc,
    output logic [31:0] id_pc,
    output logic [31:0] id_instruction,
    output logic        id_valid,
    output logic [1:0]  id_exc,
    output logic [1:0]  skid_exc
);

    logic [31:0] id_pc_q, id_pc_d;
    logic [31:0] id_insn_q, id_insn_d;
    logic        id_valid_q, id_valid_d;
    logic [1:0]  id_exc_q, id_exc_d;
    logic [31:0] skid_pc_q, skid_pc_d;
    logic [31:0] skid_insn_q, skid_insn_d;
    logic [1:0]  skid_exc_q, skid_exc_d;

    always_comb begin
        id_pc_d     = id_pc_q;
        id_insn_d   = id_insn_q;
        id_valid_d  = id_valid_q;
        id_exc_d    = id_exc_q;
        skid_pc_d   = skid_pc_q;
        skid_insn_d = skid_insn_q;
        skid_exc_d  = skid_exc_q;

        if (load) begin
            id_pc_d    = in_pc;
            id_insn_d  = in_insn;
            id_exc_d   = in_exc;
            id_valid_d = 1'b1;
        end else if (pop) begin
            id_pc_d    = skid_pc_q;
            id_insn_d  = skid_insn_q;
            id_exc_d   = skid_exc_q;
            id_valid_d = 1'b1;
        end else if (flush || advance) begin
            id_valid_d = 1'b0;
            id_exc_d   = FETCH_EXC_NONE;
        end

        // A flushed skid entry is dropped by clearing its exception tag;
        // occupancy itself is tracked by the fetch FSM.
        if (flush) begin
            skid_exc_d = FETCH_EXC_NONE;
        end else if (push) begin
            skid_pc_d   = in_pc;
            skid_insn_d = in_insn;
            skid_exc_d  = in_exc;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            id_pc_q     <= 32'd0;
            id_insn_q   <= NOP_INSN;
            id_valid_q  <= 1'b0;
            id_exc_q    <= FETCH_EXC_NONE;
            skid_pc_q   <= 32'd0;
            skid_insn_q <= NOP_INSN;
            skid_exc_q  <= FETCH_EXC_NONE;
        end else begin
            id_pc_q     <= id_pc_d;
            id_insn_q   <= id_insn_d;
            id_valid_q  <= id_valid_d;
            id_exc_q    <= id_exc_d;
            skid_pc_q   <= skid_pc_d;
            skid_insn_q <= skid_insn_d;
            skid_exc_q  <= skid_exc_d;
        end
    end

    assign id_pc          = id_pc_q;
    assign id_instruction = id_insn_q;
    assign id_valid       = id_valid_q;
    assign id_exc         = id_exc_q;
    assign skid_exc       = skid_exc_q;

endmodule

// File: rtl/elbeth_fetch_unit.sv
// ELBETH IF stage: fetch PC, imem request/ack handshake, redirect/flush handling.
// Single outstanding request; wrong-path requests are drained in FETCH_KILL.
module elbeth_fetch_unit
    import elbeth_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INSN = NOP_INSN_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] imem_addr,
    output logic        imem_req,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        imem_err,
    input  logic [31:0] pc_branch,
    input  logic        branch_taken,
    input  logic        id_stall,
    input  logic        exc_valid,
    input  logic [31:0] exc_pc,
    output logic [31:0] id_pc,
    output logic [31:0] id_instruction,
    output logic        id_valid,
    output logic [1:0]  id_exc
);

    fetch_state_e state_q, state_d;
    logic [31:0]  fetch_pc_q, pc_d;
    logic         req_q;

    logic        load, push, pop, flush;
    logic [31:0] in_pc, in_insn;
    logic [1:0]  in_exc;
    logic [1:0]  skid_exc;

    logic        can_accept, redirect, misaligned, ack_req;
    logic [31:0] target;

    assign can_accept = ~id_valid | ~id_stall;
    assign redirect   = exc_valid | (branch_taken & id_valid & ~id_stall);
    assign target     = exc_valid ? exc_pc : pc_branch;
    assign misaligned = target[1:0] != 2'b00;
    // req_q is low in the first cycle after reset, so nothing is outstanding then.
    assign ack_req    = imem_ack & req_q;

    always_comb begin
        state_d = state_q;
        pc_d    = fetch_pc_q;
        load    = 1'b0;
        push    = 1'b0;
        pop     = 1'b0;
        flush   = 1'b0;
        in_pc   = fetch_pc_q;
        in_insn = imem_rdata;
        in_exc  = FETCH_EXC_NONE;
        if (imem_err) begin
            in_insn = NOP_INSN;
            in_exc  = FETCH_EXC_BUSERR;
        end

        if (redirect) begin
            flush = 1'b1;
            pc_d  = target;
            if (misaligned) begin
                load    = 1'b1;
                in_pc   = target;
                in_insn = NOP_INSN;
                in_exc  = FETCH_EXC_MISALIGN;
            end
            unique case (state_q)
                FETCH_REQ: begin
                    if (req_q && !imem_ack) begin
                        state_d = FETCH_KILL;
                    end else begin
                        state_d = misaligned ? FETCH_HALT : FETCH_REQ;
                    end
                end
                FETCH_FULL: state_d = misaligned ? FETCH_HALT : FETCH_REQ;
                FETCH_KILL: begin
                    if (imem_ack) begin
                        state_d = misaligned ? FETCH_HALT : FETCH_REQ;
                    end
                end
                FETCH_HALT: begin
                    if (exc_valid) begin
                        state_d = misaligned ? FETCH_HALT : FETCH_REQ;
                    end
                end
            endcase
        end else begin
            unique case (state_q)
                FETCH_REQ: begin
                    if (ack_req) begin
                        if (can_accept) begin
                            load = 1'b1;
                        end else begin
                            push    = 1'b1;
                            state_d = FETCH_FULL;
                        end
                        if (imem_err) begin
                            if (can_accept) begin
                                state_d = FETCH_HALT;
                            end
                        end else begin
                            pc_d = pc_plus4(fetch_pc_q);
                        end
                    end
                end
                FETCH_FULL: begin
                    if (!id_stall) begin
                        pop     = 1'b1;
                        state_d = (skid_exc == FETCH_EXC_BUSERR) ? FETCH_HALT : FETCH_REQ;
                    end
                end
                FETCH_KILL: begin
                    // A misaligned target taken while draining was already reported.
                    if (imem_ack) begin
                        state_d = (fetch_pc_q[1:0] != 2'b00) ? FETCH_HALT : FETCH_REQ;
                    end
                end
                FETCH_HALT: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= FETCH_REQ;
            fetch_pc_q <= RESET_PC;
            req_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= pc_d;
            req_q      <= (state_d == FETCH_REQ);
        end
    end

    assign imem_req  = req_q;
    assign imem_addr = fetch_pc_q;

    elbeth_if_id_reg #(
        .NOP_INSN (NOP_INSN)
    ) u_if_id_reg (
        .clk            (clk),
        .rst_n          (rst_n),
        .load           (load),
        .push           (push),
        .pop            (pop),
        .flush          (flush),
        .advance        (~id_stall),
        .in_pc          (in_pc),
        .in_insn        (in_insn),
        .in_exc         (in_exc),
        .id_pc          (id_pc),
        .id_instruction (id_instruction),
        .id_valid       (id_valid),
        .id_exc         (id_exc),
        .skid_exc       (skid_exc)
    );

endmodule

// File: tb/tb_elbeth_fetch_unit.sv
// Directed bench for elbeth_fetch_unit with a wait-state-programmable memory model.
module tb_elbeth_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic [31:0] imem_addr;
    logic        imem_req;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        imem_err;
    logic [31:0] pc_branch;
    logic        branch_taken;
    logic        id_stall;
    logic        exc_valid;
    logic [31:0] exc_pc;
    logic [31:0] id_pc;
    logic [31:0] id_instruction;
    logic        id_valid;
    logic [1:0]  id_exc;

    int n_checks = 0;
    int n_errors = 0;

    // memory model
    logic        pend;
    logic [31:0] pend_addr;
    logic [31:0] cur_addr;
    int unsigned cnt;
    int unsigned wait_n;
    logic        err_en;
    logic [31:0] err_addr;

    elbeth_fetch_unit #(
        .RESET_PC (32'h0000_0200),
        .NOP_INSN (32'h0000_0013)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_addr      (imem_addr),
        .imem_req       (imem_req),
        .imem_ack       (imem_ack),
        .imem_rdata     (imem_rdata),
        .imem_err       (imem_err),
        .pc_branch      (pc_branch),
        .branch_taken   (branch_taken),
        .id_stall       (id_stall),
        .exc_valid      (exc_valid),
        .exc_pc         (exc_pc),
        .id_pc          (id_pc),
        .id_instruction (id_instruction),
        .id_valid       (id_valid),
        .id_exc         (id_exc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        if (pend) begin
            imem_ack = (cnt >= wait_n);
            cur_addr = pend_addr;
        end else begin
            imem_ack = imem_req && (wait_n == 0);
            cur_addr = imem_addr;
        end
        imem_rdata = cur_addr ^ 32'hA5A5_A5A5;
        imem_err   = imem_ack && err_en && (cur_addr == err_addr);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend      <= 1'b0;
            pend_addr <= 32'd0;
            cnt       <= 0;
        end else if (pend) begin
            if (imem_ack) pend <= 1'b0;
            else          cnt  <= cnt + 1;
        end else if (imem_req && !imem_ack) begin
            pend      <= 1'b1;
            pend_addr <= imem_addr;
            cnt       <= 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, " imem_req"}, {31'd0, imem_req}, 32'd0);
        check({tag, " imem_addr"}, imem_addr, 32'h200);
        check({tag, " id_valid"}, {31'd0, id_valid}, 32'd0);
        check({tag, " id_pc"}, id_pc, 32'd0);
        check({tag, " id_insn"}, id_instruction, 32'h13);
        check({tag, " id_exc"}, {30'd0, id_exc}, 32'd0);
    endtask

    initial begin
        rst_n        = 1'b0;
        id_stall     = 1'b0;
        branch_taken = 1'b0;
        pc_branch    = 32'd0;
        exc_valid    = 1'b0;
        exc_pc       = 32'd0;
        wait_n       = 0;
        err_en       = 1'b0;
        err_addr     = 32'd0;

        step();
        check_reset_values("reset");
        rst_n = 1'b1;

        // zero-wait streaming
        step();
        check("first req", {31'd0, imem_req}, 32'd1);
        check("first addr", imem_addr, 32'h200);
        check("first valid", {31'd0, id_valid}, 32'd0);
        step();
        check("addr 204", imem_addr, 32'h204);
        check("valid after ack", {31'd0, id_valid}, 32'd1);
        check("id_pc 200", id_pc, 32'h200);
        check("insn 200", id_instruction, 32'hA5A5_A7A5);
        step();
        check("addr 208", imem_addr, 32'h208);
        check("id_pc 204", id_pc, 32'h204);
        check("insn 204", id_instruction, 32'hA5A5_A7A1);

        // stall with IF/ID full: 0x208 goes to skid
        id_stall = 1'b1;
        step();
        check("stall req0 a", {31'd0, imem_req}, 32'd0);
        check("stall hold pc", id_pc, 32'h204);
        check("stall hold valid", {31'd0, id_valid}, 32'd1);
        step();
        check("stall req0 b", {31'd0, imem_req}, 32'd0);
        step();
        check("stall req0 c", {31'd0, imem_req}, 32'd0);
        check("stall still 204", id_pc, 32'h204);
        id_stall = 1'b0;
        wait_n   = 3;
        step();
        check("skid pc 208", id_pc, 32'h208);
        check("skid insn 208", id_instruction, 32'hA5A5_A7AD);
        check("req after skid", {31'd0, imem_req}, 32'd1);
        check("addr 20c", imem_addr, 32'h20C);

        // branch while 0x20C outstanding (3 wait states)
        branch_taken = 1'b1;
        pc_branch    = 32'h400;
        step();
        branch_taken = 1'b0;
        check("kill req0", {31'd0, imem_req}, 32'd0);
        check("kill flush valid", {31'd0, id_valid}, 32'd0);
        check("kill pc", imem_addr, 32'h400);
        step();
        check("kill wait req0", {31'd0, imem_req}, 32'd0);
        step();
        check("kill ack req0", {31'd0, imem_req}, 32'd0);
        wait_n = 0;
        step();
        check("post kill req", {31'd0, imem_req}, 32'd1);
        check("post kill addr", imem_addr, 32'h400);
        check("post kill valid", {31'd0, id_valid}, 32'd0);
        step();
        check("id_pc 400", id_pc, 32'h400);
        check("insn 400", id_instruction, 32'hA5A5_A1A5);
        check("valid 400", {31'd0, id_valid}, 32'd1);
        check("addr 404", imem_addr, 32'h404);

        // redirect coincident with ack
        branch_taken = 1'b1;
        pc_branch    = 32'h500;
        step();
        branch_taken = 1'b0;
        check("coinc req", {31'd0, imem_req}, 32'd1);
        check("coinc addr", imem_addr, 32'h500);
        check("coinc drop", {31'd0, id_valid}, 32'd0);
        step();
        check("id_pc 500", id_pc, 32'h500);
        check("insn 500", id_instruction, 32'hA5A5_A0A5);

        // misaligned branch target
        branch_taken = 1'b1;
        pc_branch    = 32'h402;
        step();
        branch_taken = 1'b0;
        check("mis exc", {30'd0, id_exc}, 32'd1);
        check("mis pc", id_pc, 32'h402);
        check("mis insn", id_instruction, 32'h13);
        check("mis valid", {31'd0, id_valid}, 32'd1);
        check("mis req0", {31'd0, imem_req}, 32'd0);
        step();
        check("halt req0 a", {31'd0, imem_req}, 32'd0);
        step();
        check("halt req0 b", {31'd0, imem_req}, 32'd0);
        exc_valid = 1'b1;
        exc_pc    = 32'h100;
        step();
        exc_valid = 1'b0;
        check("resume req", {31'd0, imem_req}, 32'd1);
        check("resume addr", imem_addr, 32'h100);
        step();
        check("id_pc 100", id_pc, 32'h100);
        check("insn 100", id_instruction, 32'hA5A5_A4A5);

        // bus error on 0x208
        exc_valid = 1'b1;
        exc_pc    = 32'h200;
        err_en    = 1'b1;
        err_addr  = 32'h208;
        step();
        exc_valid = 1'b0;
        check("err seq 200", imem_addr, 32'h200);
        step();
        step();
        check("err seq 208", imem_addr, 32'h208);
        step();
        check("buserr exc", {30'd0, id_exc}, 32'd2);
        check("buserr pc", id_pc, 32'h208);
        check("buserr insn", id_instruction, 32'h13);
        check("buserr valid", {31'd0, id_valid}, 32'd1);
        check("buserr req0", {31'd0, imem_req}, 32'd0);
        step();
        check("buserr halt", {31'd0, imem_req}, 32'd0);

        // asynchronous reset while a request waits
        exc_valid = 1'b1;
        exc_pc    = 32'h300;
        wait_n    = 3;
        err_en    = 1'b0;
        step();
        exc_valid = 1'b0;
        check("wait req", {31'd0, imem_req}, 32'd1);
        check("wait addr", imem_addr, 32'h300);
        step();
        #3;
        rst_n = 1'b0;
        #1;
        check_reset_values("async rst");
        step();
        rst_n  = 1'b1;
        wait_n = 0;
        step();
        check("rst restart req", {31'd0, imem_req}, 32'd1);
        check("rst restart addr", imem_addr, 32'h200);
        step();
        check("rst restart id_pc", id_pc, 32'h200);
        check("rst restart valid", {31'd0, id_valid}, 32'd1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/elbeth_fetch_unit.md
Name: elbeth_fetch_unit

Overview:
IF stage of the ELBETH pipeline. Holds the fetch PC, runs the instruction-memory request/ack handshake, and loads the IF/ID register (id_pc, id_instruction) consumed by decode and the ID-stage branch unit. Consumes the branch unit's pc_branch/branch_taken and the exception unit's redirect. Flushes wrong-path fetches, including requests still outstanding in memory.

Parameters:
RESET_PC, 32'h0000_0000, first fetch address after reset
NOP_INSN, 32'h0000_0013, instruction placed in IF/ID on bubbles (addi x0,x0,0)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
imem_addr  out  32  fetch address, equals fetch_pc, held stable while imem_req=1 and no ack
imem_req  out  1  fetch request, held until imem_ack
imem_ack  in  1  one-cycle pulse; imem_rdata/imem_err valid this cycle
imem_rdata  in  32  fetched word
imem_err  in  1  bus error on this fetch
pc_branch  in  32  branch/jump target from branch unit
branch_taken  in  1  branch unit decision for the instruction in ID
id_stall  in  1  ID cannot accept a new instruction this cycle
exc_valid  in  1  exception/trap redirect, highest priority
exc_pc  in  32  trap target
id_pc  out  32  PC of instruction in IF/ID
id_instruction  out  32  instruction in IF/ID
id_valid  out  1  IF/ID holds a real instruction
id_exc  out  2  0 none, 1 fetch misaligned, 2 fetch bus error

Behaviour:
- Reset (async, rst_n=0): fetch_pc=RESET_PC, state=S_REQ, id_valid=0, id_pc=0, id_instruction=NOP_INSN, id_exc=0, skid empty, imem_req=0. imem_req rises in the first cycle after rst_n deasserts. Reset mid-transaction drops the outstanding request, with no kill tracking.
- redirect = exc_valid | (branch_taken & id_valid & ~id_stall). Target = exc_pc if exc_valid, else pc_branch.
- States:
  - S_REQ: imem_req=1.
  - S_FULL: word buffered in skid, imem_req=0.
  - S_KILL: outstanding request must be discarded, imem_req=0.
  - S_HALT: fetch faulted, imem_req=0.
- S_REQ, ack without redirect:
  - If ID can accept (~id_valid | ~id_stall): load IF/ID with {fetch_pc, imem_rdata}, id_valid=1, fetch_pc+=4 (32-bit wrap, no carry out).
  - Otherwise: store the word in skid, fetch_pc+=4, go S_FULL.
  - imem_err=1: load IF/ID with NOP_INSN, id_exc=2, id_valid=1, go S_HALT.
- S_FULL: when ~id_stall, move skid into IF/ID and return to S_REQ. Next imem_req is asserted the cycle after the transfer.
- ID advances with no new word: id_valid=0 (bubble).
- Redirect, any state, effective next edge:
  - id_valid=0, skid cleared, fetch_pc=target.
  - S_REQ, no ack this cycle: go S_KILL.
  - S_REQ, ack in the same cycle: discard the data, stay S_REQ. New address issues next cycle.
- S_KILL: wait for imem_ack and discard that data, then go S_REQ. A further redirect while in S_KILL only updates fetch_pc.
- Target[1:0]!=0: no memory request. IF/ID gets {target, NOP_INSN}, id_exc=1, id_valid=1, go S_HALT.
- S_HALT: exits only on exc_valid. A branch redirect is ignored unless id_valid.
- Fetch throughput: single outstanding request; one instruction per cycle with zero-wait-state memory (imem_ack the same cycle as imem_req).
- Outputs are registered. imem_req/imem_addr derive from state/fetch_pc only, with no combinational path from imem_ack.

Decomposition:
- elbeth_definitions.v additions:
  - FETCH_* state encodings (2-bit).
  - FETCH_EXC_NONE/MISALIGN/BUSERR.
  - `NOP_INSN value.
- One sub-module, elbeth_if_id_reg: IF/ID pipeline register plus one-entry skid buffer with load/hold/flush controls.
- FSM and PC logic stay in the top.

Test Plan:
- Reset, RESET_PC=0x200, zero-wait memory returning addr^0xA5A5A5A5 -> imem_addr 0x200, 0x204, 0x208 on consecutive cycles; id_valid=1 from the cycle after the first ack; id_instruction=0xA5A5A7A5 with id_pc=0x200.
- id_stall=1 for 3 cycles with IF/ID full -> one word skidded, imem_req=0 during the stall, no instruction lost or duplicated; sequence continues 0x204, 0x208.
- branch_taken=1, pc_branch=0x400 while a 3-wait-state request to 0x20C is outstanding -> 0x20C data discarded; next imem_addr=0x400; id_valid=0 for the flushed slot.
- Redirect coincident with imem_ack -> ack data dropped; imem_addr=target the next cycle; no S_KILL entry.
- pc_branch=0x402 -> no request; id_exc=1, id_pc=0x402, id_instruction=0x00000013; halted until exc_valid with exc_pc=0x100 resumes fetch at 0x100.
- imem_err on fetch of 0x208 -> id_exc=2, imem_req stays 0; rst_n asserted mid-wait -> all outputs at reset values immediately, without waiting for a clock edge.
